// File: rtl/i2s_pkg.sv
// ============================================================================
// Module : i2s_pkg
// Brief  : Shared I2S types and constants (receiver and transmitter).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    localparam int c_default_width = 16;

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2s_sync.sv
// ============================================================================
// Module : i2s_sync
// Brief  : Two-flop synchronisers for SCLK and data lines, SCLK rising-edge tick.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_sync #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_sclk,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q,
    output logic         o_tick
);

    logic [1:0]   r_sclk_ff;
    logic         r_sclk_prev;
    logic [N-1:0] r_d_ff1;
    logic [N-1:0] r_d_ff2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_ff   <= '0;
            r_sclk_prev <= 1'b0;
            r_d_ff1     <= '0;
            r_d_ff2     <= '0;
        end else begin
            r_sclk_ff   <= {r_sclk_ff[0], i_sclk};
            r_sclk_prev <= r_sclk_ff[1];
            r_d_ff1     <= i_d;
            r_d_ff2     <= r_d_ff1;
        end
    end

    // Data lines share the SCLK latency, so o_q is aligned with o_tick.
    assign o_q    = r_d_ff2;
    assign o_tick = r_sclk_ff[1] & ~r_sclk_prev;

endmodule

`default_nettype wire

// File: rtl/i2s_receiver.sv
// ============================================================================
// Module : i2s_receiver
// Brief  : I2S slave receiver with valid/ready output and overrun flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCLK,
    input  logic             WS,
    input  logic             SD,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_ch,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun
);

    localparam int               c_cw        = $clog2(WIDTH + 1);
    localparam logic [c_cw-1:0]  c_cnt_full  = c_cw'(WIDTH);
    localparam logic [c_cw-1:0]  c_cnt_one   = c_cw'(1);

    logic [1:0]       w_sync;
    logic             w_tick;
    logic             w_ws;
    logic             w_sd;
    logic             w_ws_edge;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_clear;
    logic             w_shift_en;
    logic             w_done;
    logic             r_ws_prev;
    logic [WIDTH-1:0] r_shift;
    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] w_shift_in;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_ch;
    logic             r_rx_valid;
    logic             r_overrun;

    i2s_sync #(.N(2)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_sclk (SCLK),
        .i_d    ({WS, SD}),
        .o_q    (w_sync),
        .o_tick (w_tick)
    );

    assign w_ws      = w_sync[1];
    assign w_sd      = w_sync[0];
    assign w_ws_edge = (w_ws != r_ws_prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_tick && w_ws_edge) begin
            w_state_nxt = SHIFT;
        end
    end

    always_comb begin
        w_clear    = 1'b0;
        w_shift_en = 1'b0;
        w_done     = 1'b0;
        if (w_tick) begin
            case (r_state)
                SYNC: begin
                    w_clear = w_ws_edge;
                end
                SHIFT: begin
                    if (w_ws_edge) begin
                        w_done  = 1'b1;
                        w_clear = 1'b1;
                    end else begin
                        w_shift_en = 1'b1;
                    end
                end
                default: begin
                    w_clear = 1'b0;
                end
            endcase
        end
    end

    // A full count means SD is beyond the kept bits; otherwise SD is the
    // final bit and the word is left-justified with zero padding.
    assign w_shift_in = {r_shift[WIDTH-2:0], w_sd};
    assign w_word     = (r_cnt == c_cnt_full) ? r_shift
                      : (w_shift_in << (c_cnt_full - r_cnt - c_cnt_one));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ws_prev <= 1'b0;
            r_shift   <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_tick) begin
                r_ws_prev <= w_ws;
            end
            if (w_clear) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_shift_en && (r_cnt < c_cnt_full)) begin
                r_shift <= w_shift_in;
                r_cnt   <= r_cnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data  <= '0;
            r_rx_ch    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= w_word;
                    r_rx_ch    <= r_ws_prev;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_ch    = r_rx_ch;
    assign rx_valid = r_rx_valid;
    assign overrun  = r_overrun;

endmodule

`default_nettype wire
